// File: rtl/pulse_echo_scheduler_if.sv
// Configuration bus and line handshake between the pulse-echo scheduler and
// its host / display consumer. The host side drives register writes and the
// line acknowledge; the scheduler side reports line and frame completion.
interface pulse_echo_scheduler_if #(
  parameter int CNT_W = 16
) ();
  logic             cfg_we;
  logic [2:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;
  logic             line_ack;
  logic             line_done;
  logic             frame_done;

  modport master (
    output cfg_we,
    output cfg_addr,
    output cfg_wdata,
    output line_ack,
    input  line_done,
    input  frame_done
  );

  modport slave (
    input  cfg_we,
    input  cfg_addr,
    input  cfg_wdata,
    input  line_ack,
    output line_done,
    output frame_done
  );
endinterface

// File: rtl/pulse_echo_scheduler.sv
// Pulse-echo line scheduler: runs INC -> TX -> RX -> WAIT_ACK -> GAP per scan
// line, with run-time timing registers that are latched into shadow copies at
// the start of every line. All outputs come straight from flops.
// Optional build macro: PULSE_ECHO_AUTO_ACK_EN -- when defined, line_ack is
// ignored and WAIT_ACK lasts a single cycle (free-running scan).
module pulse_echo_scheduler #(
  parameter int CNT_W     = 16,
  parameter int NUM_LINES = 8,
  parameter int LINE_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  pulse_echo_scheduler_if.slave bus,
  output logic [LINE_W-1:0]     line_sel,
  output logic                  increment,
  output logic                  transmit,
  output logic                  receive,
  output logic                  z_on,
  output logic                  marker,
  output logic                  busy
);

  // Register map: 0 tx_len, 1 rx_len, 2 gap_len, 3 mark_per, 4 num_lines.
  localparam int NUM_CFG = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INC      = 3'd1,
    S_TX       = 3'd2,
    S_RX       = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t                        state_reg, state_next;
  logic [CNT_W-1:0]              cnt_reg, cnt_next;
  logic [CNT_W-1:0]              mdown_reg, mdown_next;
  logic [LINE_W-1:0]             line_sel_reg, line_next;
  logic                          frame_next;
  logic                          ack_taken;
  logic [NUM_CFG-1:0][CNT_W-1:0] shadow_vec;
  logic [CNT_W-1:0]              tx_sh, rx_sh, gap_sh, mark_sh, num_sh;

  function automatic logic [CNT_W-1:0] cfg_default(input int idx);
    case (idx)
      0:       cfg_default = CNT_W'(15);
      1:       cfg_default = CNT_W'(2000);
      2:       cfg_default = CNT_W'(20000);
      3:       cfg_default = CNT_W'(65);
      default: cfg_default = CNT_W'(NUM_LINES);
    endcase
  endfunction

  // Lengths and the marker period can never be zero; the line count is
  // clamped to what line_sel can address.
  function automatic logic [CNT_W-1:0] cfg_sanitize(input int idx, input logic [CNT_W-1:0] v);
    cfg_sanitize = v;
    case (idx)
      0, 1, 3: if (v == '0) cfg_sanitize = CNT_W'(1);
      4: begin
        if (v == '0)
          cfg_sanitize = CNT_W'(1);
        else if (v > CNT_W'(NUM_LINES))
          cfg_sanitize = CNT_W'(NUM_LINES);
      end
      default: cfg_sanitize = v;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg
      logic [CNT_W-1:0] live_reg;
      logic [CNT_W-1:0] shadow_reg;

      // Live register: host writes land here immediately.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          live_reg <= cfg_default(gi);
        else if (bus.cfg_we && (bus.cfg_addr == 3'(gi)))
          live_reg <= cfg_sanitize(gi, bus.cfg_wdata);
      end

      // Shadow copy taken once per line so mid-line writes only affect the next line.
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          shadow_reg <= cfg_default(gi);
        else if (state_reg == S_INC)
          shadow_reg <= live_reg;
      end

      assign shadow_vec[gi] = shadow_reg;
    end
  endgenerate

  assign tx_sh   = shadow_vec[0];
  assign rx_sh   = shadow_vec[1];
  assign gap_sh  = shadow_vec[2];
  assign mark_sh = shadow_vec[3];
  assign num_sh  = shadow_vec[4];

`ifdef PULSE_ECHO_AUTO_ACK_EN
  logic unused_line_ack;
  assign unused_line_ack = bus.line_ack;
  assign ack_taken       = 1'b1;
`else
  assign ack_taken       = bus.line_ack;
`endif

  // Next-state, phase counter, marker down-counter and line index.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mdown_next = mdown_reg;
    line_next  = line_sel_reg;
    frame_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (enable)
          state_next = S_INC;
      end
      S_INC: begin
        state_next = S_TX;
        cnt_next   = '0;
      end
      S_TX: begin
        if (cnt_reg == tx_sh - CNT_W'(1)) begin
          state_next = S_RX;
          cnt_next   = '0;
          mdown_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_RX: begin
        if (cnt_reg == rx_sh - CNT_W'(1)) begin
          state_next = S_WAIT_ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
          // mdown tracks cycles until the next multiple of mark_per; zero means on a multiple.
          mdown_next = (mdown_reg == '0) ? (mark_sh - CNT_W'(1)) : (mdown_reg - CNT_W'(1));
        end
      end
      S_WAIT_ACK: begin
        if (ack_taken) begin
          // >= rather than == keeps the index in range if the line count shrank.
          if (CNT_W'(line_sel_reg) >= (num_sh - CNT_W'(1))) begin
            line_next  = '0;
            frame_next = 1'b1;
          end else begin
            line_next = line_sel_reg + LINE_W'(1);
          end
          cnt_next = '0;
          if (gap_sh == '0)
            state_next = enable ? S_INC : S_IDLE;
          else
            state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_reg == gap_sh - CNT_W'(1)) begin
          state_next = enable ? S_INC : S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State/counter registers and output flops decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      mdown_reg      <= '0;
      line_sel_reg   <= '0;
      increment      <= 1'b0;
      transmit       <= 1'b0;
      receive        <= 1'b0;
      z_on           <= 1'b0;
      marker         <= 1'b0;
      busy           <= 1'b0;
      bus.line_done  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      mdown_reg      <= mdown_next;
      line_sel_reg   <= line_next;
      increment      <= (state_next == S_INC);
      transmit       <= (state_next == S_TX);
      receive        <= (state_next == S_RX);
      z_on           <= (state_next == S_RX) && (cnt_next >= mark_sh);
      marker         <= (state_next == S_RX) && (cnt_next != '0) && (mdown_next == '0);
      busy           <= (state_next != S_IDLE);
      bus.line_done  <= (state_next == S_WAIT_ACK);
      bus.frame_done <= frame_next;
    end
  end

  assign line_sel = line_sel_reg;

endmodule

// File: tb/tb_pulse_echo_scheduler.sv
// Self-checking bench for pulse_echo_scheduler: a phase-level model built
// from the line timing rules is compared against every output on every
// falling edge, alongside directed scenarios with hand-computed expectations.
module tb_pulse_echo_scheduler;
  localparam int CNT_W     = 16;
  localparam int NUM_LINES = 8;
  localparam int LINE_W    = 3;

  localparam int PH_IDLE = 0, PH_INC = 1, PH_TX = 2, PH_RX = 3, PH_WAIT = 4, PH_GAP = 5;

  logic              clk    = 1'b0;
  logic              reset  = 1'b0;
  logic              enable = 1'b0;
  logic [LINE_W-1:0] line_sel;
  logic              increment, transmit, receive, z_on, marker, busy;

  pulse_echo_scheduler_if #(.CNT_W(CNT_W)) bus ();

  pulse_echo_scheduler #(.CNT_W(CNT_W), .NUM_LINES(NUM_LINES), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .line_sel  (line_sel),
    .increment (increment),
    .transmit  (transmit),
    .receive   (receive),
    .z_on      (z_on),
    .marker    (marker),
    .busy      (busy)
  );

  always #100 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_def [5] = '{15, 2000, 20000, 65, NUM_LINES};
  int m_cfg [5];
  int m_sh  [5];
  int m_ph, m_k, m_line;
  bit m_frame;

  function automatic int sanit(input int a, input int v);
    if (a == 0 || a == 1 || a == 3) return (v == 0) ? 1 : v;
    if (a == 4) return (v < 1) ? 1 : ((v > NUM_LINES) ? NUM_LINES : v);
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit ack;
    if (reset) begin
      m_ph = PH_IDLE; m_k = 0; m_line = 0; m_frame = 1'b0;
      m_cfg = m_def;  m_sh = m_def;
    end else begin
      m_frame = 1'b0;
`ifdef PULSE_ECHO_AUTO_ACK_EN
      ack = 1'b1;
`else
      ack = bus.line_ack;
`endif
      case (m_ph)
        PH_IDLE: if (enable) m_ph = PH_INC;
        PH_INC:  begin m_sh = m_cfg; m_ph = PH_TX; m_k = 0; end
        PH_TX:   begin m_k++; if (m_k == m_sh[0]) begin m_ph = PH_RX; m_k = 0; end end
        PH_RX:   begin m_k++; if (m_k == m_sh[1]) begin m_ph = PH_WAIT; m_k = 0; end end
        PH_WAIT: if (ack) begin
          if (m_line >= m_sh[4] - 1) begin m_line = 0; m_frame = 1'b1; end
          else m_line++;
          if (m_sh[2] == 0) m_ph = enable ? PH_INC : PH_IDLE;
          else begin m_ph = PH_GAP; m_k = 0; end
        end
        PH_GAP:  begin m_k++; if (m_k == m_sh[2]) begin m_ph = enable ? PH_INC : PH_IDLE; m_k = 0; end end
        default: m_ph = PH_IDLE;
      endcase
      if (bus.cfg_we && bus.cfg_addr < 3'd5)
        m_cfg[bus.cfg_addr] = sanit(int'(bus.cfg_addr), int'(bus.cfg_wdata));
    end
  end

  // ---------------- per-line statistics ----------------
  int ln = -1;
  int s_tx [64], s_rx [64], s_mk [64], s_fmk [64], s_lmk [64], s_z [64], s_fz [64];

  // Compare process: every output against the model, plus line statistics.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("increment",  increment,      m_ph == PH_INC);
      chk("transmit",   transmit,       m_ph == PH_TX);
      chk("receive",    receive,        m_ph == PH_RX);
      chk("z_on",       z_on,           (m_ph == PH_RX) && (m_k >= m_sh[3]));
      chk("marker",     marker,         (m_ph == PH_RX) && (m_k != 0) && (m_k % m_sh[3] == 0));
      chk("line_done",  bus.line_done,  m_ph == PH_WAIT);
      chk("frame_done", bus.frame_done, m_frame);
      chk("busy",       busy,           m_ph != PH_IDLE);
      chk("line_sel",   line_sel,       m_line);
      if (increment) begin
        ln++;
        if (ln >= 0 && ln < 64) begin
          s_tx[ln] = 0; s_rx[ln] = 0; s_mk[ln] = 0; s_z[ln] = 0;
          s_fmk[ln] = -1; s_lmk[ln] = -1; s_fz[ln] = -1;
        end
      end
      if (ln >= 0 && ln < 64) begin
        if (transmit) s_tx[ln]++;
        if (receive) begin
          if (marker) begin
            s_mk[ln]++;
            if (s_fmk[ln] < 0) s_fmk[ln] = s_rx[ln];
            s_lmk[ln] = s_rx[ln];
          end
          if (z_on) begin
            s_z[ln]++;
            if (s_fz[ln] < 0) s_fz[ln] = s_rx[ln];
          end
          s_rx[ln]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfg_write(input int a, input int d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(a);
    bus.cfg_wdata = CNT_W'(d);
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    int cyc, cnt_a, cnt_b;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.line_ack = 1'b1;
    #10 reset = 1'b1;
    #10 chk_on = 1'b1;
    enable = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Defaults, free acks: increment on the first cycle after reset release.
    tick();
    chk("first_increment", increment, 1);
    chk("first_line_sel", line_sel, 0);
    cyc = 0; while (!receive && cyc < 100) begin tick(); cyc++; end
    chk("reach_rx_line0", receive, 1);
    repeat (100) tick();
    cfg_write(0, 3); cfg_write(1, 10); cfg_write(3, 4); cfg_write(2, 2); cfg_write(4, 3);
    cyc = 0; while (!bus.frame_done && cyc < 30000) begin tick(); cyc++; end
    chk("frame_done_seen", bus.frame_done, 1);
    chk("wrap_line_sel", line_sel, 0);
    chk("lines_in_frame", ln, 2);
    chk("l0_tx_cycles", s_tx[0], 15);
    chk("l0_rx_cycles", s_rx[0], 2000);
    chk("l0_markers", s_mk[0], 30);
    chk("l0_first_marker", s_fmk[0], 65);
    chk("l0_z_cycles", s_z[0], 1935);
    chk("l0_first_z", s_fz[0], 65);
    chk("l1_tx_cycles", s_tx[1], 3);
    chk("l1_rx_cycles", s_rx[1], 10);
    chk("l1_markers", s_mk[1], 2);
    chk("l1_first_marker", s_fmk[1], 4);
    chk("l1_last_marker", s_lmk[1], 8);

`ifndef PULSE_ECHO_AUTO_ACK_EN
    // Hold acknowledge low for 50 cycles of WAIT_ACK.
    bus.line_ack = 1'b0;
    cyc = 0; while (!bus.line_done && cyc < 200) begin tick(); cyc++; end
    chk("reach_wait_ack", bus.line_done, 1);
    cnt_a = 1; cnt_b = 0;
    repeat (49) begin
      tick();
      if (bus.line_done) cnt_a++;
      if (increment) cnt_b++;
    end
    bus.line_ack = 1'b1;
    tick();
    chk("held_line_done_cycles", cnt_a, 50);
    chk("no_increment_while_held", cnt_b, 0);
    chk("gap_after_ack_line_done", bus.line_done, 0);
    chk("gap_after_ack_busy", busy, 1);
    chk("gap_after_ack_line_sel", line_sel, 1);
`endif

    // Drop enable during TX of line 1.
    cyc = 0; while (!(transmit && line_sel == 1) && cyc < 300) begin tick(); cyc++; end
    chk("reach_tx_line1", transmit && line_sel == 1, 1);
    enable = 1'b0;
    cyc = 0; while (busy && cyc < 300) begin tick(); cyc++; end
    chk("idle_busy", busy, 0);
    chk("idle_line_sel", line_sel, 2);
    cfg_write(4, 20);
    repeat (4) tick();
    chk("idle_stays_quiet", increment, 0);
    enable = 1'b1;
    tick();
    chk("resume_increment", increment, 1);
    chk("resume_line_sel", line_sel, 2);

    // Randomized traffic; num_lines is left alone here.
    repeat (3000) begin
      int r;
      enable       = ($urandom_range(0, 9) != 0);
      bus.line_ack = ($urandom_range(0, 2) != 0);
      bus.cfg_we   = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 6));
      bus.cfg_addr = (r < 4) ? 3'(r) : 3'(r + 1);
      case (r)
        0:       bus.cfg_wdata = CNT_W'($urandom_range(0, 5));
        1:       bus.cfg_wdata = CNT_W'($urandom_range(0, 12));
        2:       bus.cfg_wdata = CNT_W'($urandom_range(0, 3));
        3:       bus.cfg_wdata = CNT_W'($urandom_range(0, 5));
        default: bus.cfg_wdata = CNT_W'($urandom);
      endcase
      tick();
    end
    bus.cfg_we = 1'b0; enable = 1'b1; bus.line_ack = 1'b1;

    // Park at line 0 with a nonzero gap, then shrink the frame to one line.
    cfg_write(2, 3);
    cyc = 0; while (!bus.frame_done && cyc < 3000) begin tick(); cyc++; end
    chk("frame_a", bus.frame_done, 1);
    tick();
    cyc = 0; while (!bus.frame_done && cyc < 3000) begin tick(); cyc++; end
    chk("frame_b", bus.frame_done, 1);
    enable = 1'b0;
    cyc = 0; while (busy && cyc < 300) begin tick(); cyc++; end
    chk("parked_idle", busy, 0);
    chk("parked_line_sel", line_sel, 0);
    cfg_write(4, 0);
    enable = 1'b1;
    cnt_a = 0;
    repeat (120) begin
      tick();
      chk("single_line_sel", line_sel, 0);
      if (bus.frame_done) cnt_a++;
    end
    chk("single_line_frames_seen", cnt_a > 0, 1);

    // Reset in the middle of RX.
    cyc = 0; while (!receive && cyc < 500) begin tick(); cyc++; end
    chk("reach_rx_before_reset", receive, 1);
    tick();
    #20 reset = 1'b1;
    #1;
    chk("rst_increment", increment, 0);
    chk("rst_transmit", transmit, 0);
    chk("rst_receive", receive, 0);
    chk("rst_z_on", z_on, 0);
    chk("rst_marker", marker, 0);
    chk("rst_line_done", bus.line_done, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_sel", line_sel, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("restart_increment", increment, 1);
    chk("restart_line_sel", line_sel, 0);
    cnt_a = 0; cyc = 0;
    while (!receive && cyc < 100) begin
      tick(); cyc++;
      if (transmit) cnt_a++;
    end
    chk("restart_default_tx_cycles", cnt_a, 15);
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pulse_echo_scheduler.md
Name: pulse_echo_scheduler

Overview:
- Sequences one pulse-echo acquisition per scan line across a programmable set of transducer lines, producing increment, transmit, receive, depth-gate (z_on) and depth-marker timing.
- Sits between the 5 MHz clock-divider domain and the transmit driver, receive front end and display logic.
- Replaces fixed-delay line timing with run-time register configuration, line scheduling and a line-done handshake to the display consumer.

Parameters:
- CNT_W, 16, width of timing counters and config registers.
- NUM_LINES, 8, maximum scan lines per frame.
- LINE_W, 3, width of line index; must satisfy 2^LINE_W >= NUM_LINES.

Ports:
- clk  in  1  acquisition clock, 5 MHz nominal.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run request; level-sensitive.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  register select: 0 tx_len, 1 rx_len, 2 gap_len, 3 mark_per, 4 num_lines.
- cfg_wdata  in  CNT_W  write data.
- line_ack  in  1  display consumer has taken the line.
- line_sel  out  LINE_W  active scan line index.
- increment  out  1  one-cycle pulse at line start.
- transmit  out  1  transmit burst gate.
- receive  out  1  receive window gate.
- z_on  out  1  depth gate; high once echo depth reaches 1 cm.
- marker  out  1  one-cycle depth marker pulse.
- line_done  out  1  line complete, awaiting ack.
- frame_done  out  1  one-cycle pulse after the last line of a frame is acked.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Config registers reset to tx_len=15, rx_len=2000, gap_len=20000, mark_per=65, num_lines=NUM_LINES.
  - Writes land immediately in the live registers.
  - Live values are copied into shadow registers in INC; timing uses only the shadow copies, so a mid-line write affects the next line.
  - cfg_addr 5..7 is ignored.
  - A write of 0 to tx_len, rx_len or mark_per is stored as 1.
  - num_lines is clamped to the range 1..NUM_LINES.
- States: IDLE, INC, TX, RX, WAIT_ACK, GAP.
  - IDLE: all outputs 0. Goes to INC on the first clk edge with enable=1.
  - INC: lasts 1 cycle; increment=1; shadow regs loaded; counter cleared.
  - TX: transmit=1 for exactly tx_len cycles, then go to RX with the counter cleared.
  - RX: receive=1 for exactly rx_len cycles. Counter c runs 0..rx_len-1.
    - z_on = (c >= mark_per).
    - marker = (c != 0) && (c mod mark_per == 0); computed with a separate down-counter, no divider.
  - WAIT_ACK: line_done=1 until line_ack is sampled high, then go to GAP. line_ack outside WAIT_ACK is ignored.
  - GAP: gap_len cycles with all gates low.
    - gap_len=0 means zero gap cycles: the next state follows WAIT_ACK directly.
    - At the end of GAP: go to INC if enable=1, else IDLE.
- line_sel:
  - Resets to 0 and stays constant for the whole line.
  - Advances on leaving WAIT_ACK: wraps to 0 when line_sel == num_lines-1, otherwise increments.
  - frame_done pulses in the same cycle as the wrap.
- enable deasserted mid-line: the current line completes through WAIT_ACK and GAP, then the block returns to IDLE. line_sel is kept, so re-enabling resumes at the next line.
- Simultaneous cfg write to num_lines and a wrap: the old shadow value governs the wrap decision.
- reset asserted at any time: state to IDLE, every output 0 asynchronously, config registers to defaults, counters cleared.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: PULSE_ECHO_AUTO_ACK_EN.
  - Defined: line_ack is ignored; WAIT_ACK lasts exactly 1 cycle with line_done=1, then moves on (free-running scan).
  - Undefined: WAIT_ACK holds until line_ack, as described above.

Test Plan:
- Reset defaults, enable=1, line_ack tied high:
  - increment at cycle 1.
  - transmit high for 15 cycles, receive for 2000.
  - First marker at rx count 65, 30 markers per line.
  - z_on from rx count 65 to 1999.
- Write tx_len=3, rx_len=10, mark_per=4, gap_len=2, num_lines=3 during RX of line 0:
  - line 0 keeps the old timing.
  - line 1 has transmit 3 cycles, receive 10, markers at rx counts 4 and 8.
  - frame_done pulses on the line 2 ack; line_sel returns to 0.
- Hold line_ack low 50 cycles in WAIT_ACK:
  - line_done stays high for 50 cycles.
  - No increment occurs.
  - GAP starts the cycle after line_ack is sampled.
- Drop enable during TX of line 1:
  - line completes, block enters IDLE, busy=0, line_sel=2.
  - Re-enable gives increment with line_sel=2.
- Assert reset mid-RX: all outputs 0 immediately; cfg readback matches defaults; restart gives line_sel=0.
- With PULSE_ECHO_AUTO_ACK_EN defined and line_ack=0: line_done is a 1-cycle pulse per line and lines advance continuously.
